// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver presenting bytes on a valid/ready handshake.
// Build option UART_RX_MAJORITY_EN: each bit decision is a 2-of-3 vote over the last three ticks.
module uart_rx #(
    parameter int TICK_DIV   = 7,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       serial_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] MID   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST  = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

    state_t        state, state_nxt;
    logic [1:0]    sync_pipe;
    logic          rx_s;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shreg, shreg_nxt, rx_byte_nxt;
    logic          rx_valid_nxt, frame_error_nxt, overrun_nxt;
    logic          bit_val;

    assign rx_s = sync_pipe[1];
    assign tick = (tick_cnt == TLAST);
    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_pipe <= 2'b11;
            tick_cnt  <= '0;
        end else begin
            sync_pipe <= {sync_pipe[0], serial_rx};
            tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // hist[0] is rx_s at the previous tick, hist[1] the tick before that
    logic [1:0] hist;
    always_ff @(posedge clock) begin
        if (!reset_n)  hist <= 2'b11;
        else if (tick) hist <= {hist[0], rx_s};
    end
    assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        bit_idx_nxt     = bit_idx;
        shreg_nxt       = shreg;
        rx_byte_nxt     = rx_byte;
        rx_valid_nxt    = rx_valid & ~rx_ready;
        frame_error_nxt = 1'b0;
        overrun_nxt     = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nxt = START;
                        cnt_nxt   = '0;
                    end
                end
                START: begin
                    if (cnt == MID) begin
                        cnt_nxt = '0;
                        if (bit_val) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt   = DATA;
                            bit_idx_nxt = '0;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt_nxt   = '0;
                        shreg_nxt = {bit_val, shreg[7:1]};
                        if (bit_idx == 3'd7) state_nxt   = STOP;
                        else                 bit_idx_nxt = bit_idx + 3'd1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt_nxt = '0;
                        if (bit_val) begin
                            // a same-cycle accept frees the slot, so that is not an overrun
                            rx_byte_nxt  = shreg;
                            rx_valid_nxt = 1'b1;
                            overrun_nxt  = rx_valid & ~rx_ready;
                            state_nxt    = IDLE;
                        end else begin
                            frame_error_nxt = 1'b1;
                            state_nxt       = RECOVER;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                RECOVER: begin
                    if (rx_s) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_byte     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            shreg       <= shreg_nxt;
            rx_byte     <= rx_byte_nxt;
            rx_valid    <= rx_valid_nxt;
            frame_error <= frame_error_nxt;
            overrun     <= overrun_nxt;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames onto serial_rx and checks delivered bytes, error pulses
// and busy against a frame-level expectation list built by the bench.
module tb_uart_rx;
    localparam int BIT = 112;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       serial_rx;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       frame_error;
    logic       overrun;
    logic       busy;

    int   n_cmp = 0, n_err = 0;
    int   cyc = 0;
    logic ready_dir = 1'b1, rnd_ready = 1'b0;
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    int   fe_cnt = 0, ov_cnt = 0, vld_cyc = 0;
    logic vld_d = 1'b0;

    uart_rx #(.TICK_DIV(7), .OVERSAMPLE(16)) dut (
        .clock(clock), .reset_n(reset_n), .serial_rx(serial_rx),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_error(frame_error), .overrun(overrun), .busy(busy)
    );

    always #5 clock = ~clock;

    // clocks since the last reset edge; oversample ticks fall on multiples of 7
    always @(posedge clock) cyc <= (!reset_n) ? 0 : cyc + 1;

    always @(posedge clock) begin
        #2;
        rx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_dir;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (rx_valid && rx_ready) obs_q.push_back(rx_byte);
            if (frame_error) fe_cnt++;
            if (overrun) ov_cnt++;
            if (rx_valid) vld_cyc++;
            if (rx_valid && !vld_d) chk("busy_at_valid", {31'd0, busy}, 32'd0);
        end
        vld_d = rx_valid;
    end

    function automatic logic [31:0] last_obs();
        if (obs_q.size() == 0) return 32'hdead_beef;
        return {24'd0, obs_q[obs_q.size()-1]};
    endfunction

    task automatic hold(input logic v, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #1;
            serial_rx = v;
        end
    endtask

    // rst_bit: frame bit index (1..8 = data 0..7) in which reset is pulsed; glitch: bit-0 sample tick forced low
    task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_bit, input bit glitch);
        logic [9:0] bits;
        int jt;
        bits = {stop, b, 1'b0};
        if (glitch) begin
            do begin @(posedge clock); #1; end while (cyc % 7 != 3);
        end
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < BIT; j++) begin
                @(posedge clock); #1;
                jt = i * BIT + j;
                serial_rx = bits[i];
                if (glitch && jt >= 165 && jt <= 171) serial_rx = 1'b0;
                if (i == rst_bit && j == 50) reset_n = 1'b0;
                if (i == rst_bit && j == 51) begin
                    reset_n = 1'b1;
                    chk("rst_mid_byte", {24'd0, rx_byte}, 32'h0);
                    chk("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
                    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
                    chk("rst_mid_fe", {31'd0, frame_error}, 32'd0);
                    chk("rst_mid_ov", {31'd0, overrun}, 32'd0);
                end
            end
        end
    endtask

    initial begin
        int o0, v0, f0, q0, exp_fe;
        logic [7:0] b;
        logic       st;
        serial_rx = 1'b1;
        reset_n   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_byte", {24'd0, rx_byte}, 32'h0);
        chk("rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_fe", {31'd0, frame_error}, 32'd0);
        chk("rst_ov", {31'd0, overrun}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        hold(1'b1, 2 * BIT);

        // single clean frame
        o0 = obs_q.size(); v0 = vld_cyc; f0 = fe_cnt;
        send_frame(8'h41, 1'b1, -1, 1'b0);
        hold(1'b1, BIT);
        chk("s41_count", obs_q.size() - o0, 1);
        chk("s41_byte", last_obs(), 32'h41);
        chk("s41_valid_cycles", vld_cyc - v0, 1);
        chk("s41_no_fe", fe_cnt - f0, 0);

        // false start: 21 clocks low
        o0 = obs_q.size(); f0 = fe_cnt;
        for (int j = 0; j < 71; j++) begin
            @(posedge clock); #1;
            serial_rx = (j < 21) ? 1'b0 : 1'b1;
            if (j == 18) chk("fs_busy_high", {31'd0, busy}, 32'd1);
        end
        chk("fs_busy_clear", {31'd0, busy}, 32'd0);
        hold(1'b1, BIT);
        chk("fs_no_byte", obs_q.size() - o0, 0);
        chk("fs_no_fe", fe_cnt - f0, 0);

        // framing error followed by a break, then a good frame
        o0 = obs_q.size(); f0 = fe_cnt;
        send_frame(8'h55, 1'b0, -1, 1'b0);
        hold(1'b0, 5 * BIT);
        hold(1'b1, 2 * BIT);
        send_frame(8'hA5, 1'b1, -1, 1'b0);
        hold(1'b1, BIT);
        chk("brk_fe_count", fe_cnt - f0, 1);
        chk("brk_byte_count", obs_q.size() - o0, 1);
        chk("brk_byte", last_obs(), 32'hA5);

        // overrun with consumer stalled
        o0 = obs_q.size(); f0 = ov_cnt;
        ready_dir = 1'b0;
        hold(1'b1, 4);
        send_frame(8'h12, 1'b1, -1, 1'b0);
        send_frame(8'h34, 1'b1, -1, 1'b0);
        hold(1'b1, 20);
        chk("ovr_count", ov_cnt - f0, 1);
        chk("ovr_valid", {31'd0, rx_valid}, 32'd1);
        chk("ovr_byte", {24'd0, rx_byte}, 32'h34);
        ready_dir = 1'b1;
        for (int k = 0; k < 10 && !rx_ready; k++) @(negedge clock);
        @(negedge clock);
        chk("ovr_accept_clear", {31'd0, rx_valid}, 32'd0);
        chk("ovr_accepted", last_obs(), 32'h34);
        chk("ovr_accept_count", obs_q.size() - o0, 1);

        // reset mid-frame during data bit 3
        o0 = obs_q.size();
        send_frame(8'hFF, 1'b1, 4, 1'b0);
        hold(1'b1, BIT);
        chk("rst_no_byte", obs_q.size() - o0, 0);
        send_frame(8'h7E, 1'b1, -1, 1'b0);
        hold(1'b1, BIT);
        chk("rst_next_byte", last_obs(), 32'h7E);

        // single-tick glitch on the bit-0 sample
        o0 = obs_q.size();
        send_frame(8'hFF, 1'b1, -1, 1'b1);
        hold(1'b1, BIT);
        chk("glitch_count", obs_q.size() - o0, 1);
`ifdef UART_RX_MAJORITY_EN
        chk("glitch_byte", last_obs(), 32'hFF);
`else
        chk("glitch_byte", last_obs(), 32'hFE);
`endif

        // randomized frames with random consumer stalls
        q0 = obs_q.size(); f0 = fe_cnt; v0 = ov_cnt; exp_fe = 0;
        exp_q.delete();
        rnd_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            b  = 8'($urandom);
            st = ($urandom_range(0, 4) != 0);
            if (st) exp_q.push_back(b);
            else    exp_fe++;
            send_frame(b, st, -1, 1'b0);
            hold(1'b1, $urandom_range(BIT, 300));
        end
        hold(1'b1, 50);
        rnd_ready = 1'b0;
        hold(1'b1, 10);
        chk("rnd_byte_count", obs_q.size() - q0, exp_q.size());
        chk("rnd_fe_count", fe_cnt - f0, exp_fe);
        chk("rnd_no_overrun", ov_cnt - v0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (q0 + i < obs_q.size()) chk("rnd_byte", {24'd0, obs_q[q0+i]}, {24'd0, exp_q[i]});
            else                       chk("rnd_byte_missing", 32'd0, {24'd0, exp_q[i]} | 32'h100);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: the receive half of the team's UART, paired with the existing 8N1 transmitter on the same `clock` domain. It oversamples the `serial_rx` line, recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) and presents each byte on a valid/ready handshake to the consuming logic. Framing errors and overruns are reported as single-cycle pulses.

## Interface

- `TICK_DIV`, 7: clock cycles per oversample tick; must be ≥1.
- `OVERSAMPLE`, 16: ticks per bit period; must be even and ≥8. Bit period = TICK_DIV × OVERSAMPLE clocks.

- `clock` input 1: sole clock; all logic on rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `serial_rx` input 1: asynchronous line; idle high.
- `rx_byte` output 8: last received byte; stable while `rx_valid`=1 unless overwritten on overrun.
- `rx_valid` output 1: byte available; held until accepted.
- `rx_ready` input 1: consumer accepts byte in a cycle where `rx_valid`=1.
- `frame_error` output 1: one-cycle pulse when the stop bit samples low.
- `overrun` output 1: one-cycle pulse when a new byte overwrites an unaccepted one.
- `busy` output 1: high whenever the FSM is not IDLE.

## Operation

- Input sync: two flops on `serial_rx`, both reset to 1; FSM sees only the synchronized `rx_s`.
- Tick generator: counter 0..TICK_DIV-1; `tick` pulses one cycle when counter = TICK_DIV-1; free-running after reset.
- FSM advances only on `tick`. `cnt` counts ticks within a bit; `bit_idx` counts 0..7.
  - IDLE: `rx_s`=0 → START, `cnt`=0.
  - START: `cnt` increments; at `cnt`=OVERSAMPLE/2-1, sample. Sample 1 → IDLE (false start, nothing reported). Sample 0 → DATA, `cnt`=0, `bit_idx`=0.
  - DATA: at `cnt`=OVERSAMPLE-1, sample; shift into shift register MSB (LSB-first reassembly); `cnt`=0. After `bit_idx`=7 → STOP; otherwise `bit_idx`+1.
  - STOP: at `cnt`=OVERSAMPLE-1, sample. Sample 1 → load `rx_byte`, set `rx_valid`, then IDLE. Sample 0 → pulse `frame_error`, byte discarded, then RECOVER.
  - RECOVER: stay until a tick with `rx_s`=1, then IDLE. This prevents a held-low break from being read as repeated 0x00 frames.
- Handshake: `rx_valid` clears on the edge after a cycle with `rx_valid`&`rx_ready`.
- Byte completion while `rx_valid`=1 and `rx_ready`=0: overwrite `rx_byte`, keep `rx_valid`=1, pulse `overrun`.
- Byte completion in the same cycle as acceptance: new byte loaded, `rx_valid` stays 1, no `overrun`.
- Reset values: `rx_byte`=0x00, `rx_valid`=0, `frame_error`=0, `overrun`=0, `busy`=0. FSM returns to IDLE, counters go to 0, sync flops go to 1.
- Reset mid-frame: the partial byte is discarded and never reported.

## Timing

- Input-to-FSM latency: 2 clocks of synchronizer.
- Start detection resolution: 1 tick (TICK_DIV clocks).
- Each data sample lands one bit period after the previous one; the first lands one bit period after the start-bit midpoint.
- `rx_valid`, `rx_byte`, `frame_error` and `overrun` all update on the clock edge that processes the stop-bit tick.
- `busy` rises on the edge that enters START and falls on the edge that enters IDLE.
- `frame_error` and `overrun` are exactly one clock wide.

## Configuration

- `UART_RX_MAJORITY_EN` defined: each start, data and stop decision is the 2-of-3 majority of `rx_s` on the three ticks ending at the sample point (`cnt`=P-2, P-1, P, where P is the sample point).
- Undefined: single sample at P only.
- Frame timing and outputs are otherwise identical in both builds.

## Test plan

All scenarios use TICK_DIV=7, OVERSAMPLE=16, giving 112 clocks per bit.

- Frame 0x41 with `rx_ready`=1 → `rx_byte`=0x41 and `rx_valid` for one cycle; `frame_error`=0; `busy` falls with the valid edge.
- `serial_rx` low for 21 clocks, then high → no `rx_valid`; `busy` returns to 0 within ≤9 ticks.
- Frame 0x55 with low stop bit, line then held low 5 bit times, then high, then frame 0xA5 → one `frame_error` pulse; the only byte delivered is 0xA5.
- Back-to-back frames 0x12, 0x34 with `rx_ready`=0 → `overrun` pulses once; `rx_byte`=0x34 with `rx_valid`=1; raising `rx_ready` clears `rx_valid` next edge.
- Frame 0xFF with `reset_n` pulsed low for 1 cycle during data bit 3 → all outputs at reset values, no byte delivered; the next frame 0x7E is received as 0x7E.
- Frame 0xFF with `rx_s` forced low only on the bit-0 sample tick → 0xFF with `UART_RX_MAJORITY_EN`, 0xFE without it.
